// File: rtl/div_pkg.sv
// Shared definitions for the division datapath: FSM state encoding and the default operand width.
package div_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/restoring_multiply_check_shift_add_step.sv
// One shift-add multiply iteration: conditionally add the multiplicand, then shift both operands.
module shift_add_step #(
    parameter int WIDTH = 8
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0]   mplier_o
);

    // Next accumulator and operand values for a single iteration.
    always_comb begin
        acc_o    = acc_i;
        mcand_o  = mcand_i << 1;
        mplier_o = mplier_i >> 1;
        if (mplier_i[0]) begin
            acc_o = acc_i + mcand_i;
        end else begin
            acc_o = acc_i;
        end
    end

endmodule

// File: rtl/restoring_multiply_check.sv
// Sequential shift-add multiply-accumulate (multiplicand * multiplier + addend) rebuilding a dividend.
// Optional DIV_CHECK_EN adds an expected-value input and a registered mismatch flag.
module restoring_multiply_check
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   addend,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
`ifdef DIV_CHECK_EN
    ,
    input  logic [2*WIDTH-1:0] expected,
    output logic               mismatch
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   count_q;
    logic [2*WIDTH-1:0] product_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mcand_d;
    logic [WIDTH-1:0]   mplier_d;
`ifdef DIV_CHECK_EN
    logic [2*WIDTH-1:0] expected_q;
    logic               mismatch_q;
`endif

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (acc_d),
        .mcand_o  (mcand_d),
        .mplier_o (mplier_d)
    );

    // Control FSM and datapath registers; exactly WIDTH RUN cycles, no early exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            count_q    <= '0;
            product_q  <= '0;
`ifdef DIV_CHECK_EN
            expected_q <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q      <= {{WIDTH{1'b0}}, addend};
                        mcand_q    <= {{WIDTH{1'b0}}, multiplicand};
                        mplier_q   <= multiplier;
                        count_q    <= '0;
`ifdef DIV_CHECK_EN
                        expected_q <= expected;
`endif
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    count_q  <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        product_q  <= acc_d;
`ifdef DIV_CHECK_EN
                        // A remainder >= divisor shows up here as a product/dividend difference.
                        mismatch_q <= (acc_d != expected_q);
`endif
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
`ifdef DIV_CHECK_EN
                        mismatch_q <= 1'b0;
`endif
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;
`ifdef DIV_CHECK_EN
    assign mismatch  = mismatch_q;
`endif

endmodule

// File: tb/tb_restoring_multiply_check.sv
// Scoreboard bench for restoring_multiply_check: driver pushes expected results, monitor pops on output.
module tb_restoring_multiply_check;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        int             acc_cyc;
        logic           mm;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [W-1:0]   addend;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;
    logic [2*W-1:0] expected_in;
`ifdef DIV_CHECK_EN
    logic           mismatch;
`endif

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   rdy_mode = 2;
    logic prev_ov = 1'b0;
    logic prev_hs = 1'b0;

    restoring_multiply_check #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .addend       (addend),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
`ifdef DIV_CHECK_EN
        ,
        .expected     (expected_in),
        .mismatch     (mismatch)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer: out_ready random, forced low, or forced high.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
            else if (rdy_mode == 1) out_ready = 1'b0;
            else out_ready = 1'b1;
        end
    end

    // Monitor: compares against the scoreboard whenever a result is presented.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
            prev_hs = 1'b0;
        end else begin
            check("busy_is_not_in_ready", {31'd0, busy}, {31'd0, !in_ready});
            if (prev_hs) begin
                check("in_ready_after_out_hs", {31'd0, in_ready}, 32'd1);
                check("out_valid_after_out_hs", {31'd0, out_valid}, 32'd0);
            end
            prev_hs = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got product %0d with empty scoreboard", product);
                end else begin
                    if (!prev_ov) check("latency_cycle", cyc, q[0].acc_cyc + W);
                    check("product", {16'd0, product}, {16'd0, q[0].prod});
`ifdef DIV_CHECK_EN
                    check("mismatch", {31'd0, mismatch}, {31'd0, q[0].mm});
`endif
                    if (out_ready) begin
                        void'(q.pop_front());
                        prev_hs = 1'b1;
                    end
                end
            end else begin
`ifdef DIV_CHECK_EN
                check("mismatch_idle", {31'd0, mismatch}, 32'd0);
`endif
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [2*W-1:0] pexp, input logic [2*W-1:0] chk);
        int   waitc = 0;
        exp_t e;
        @(negedge clk);
        mcand = a; mplier = b; addend = c; expected_in = chk; in_valid = 1'b1;
        while (!in_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready still %0d after %0d cycles", in_ready, waitc);
            in_valid = 1'b0;
            return;
        end
        e.prod = pexp;
        e.acc_cyc = cyc + 1;
        e.mm = (pexp != chk);
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mcand = W'($urandom); mplier = W'($urandom); addend = W'($urandom);
        expected_in = (2*W)'($urandom);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, 0 required", q.size());
        end
    endtask

    initial begin
        int wc;
        int p;
        logic [W-1:0] a, b, c;
        logic [2*W-1:0] chk;
        rst = 1'b1; in_valid = 1'b0; mcand = '0; mplier = '0; addend = '0; expected_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_product", {16'd0, product}, 32'd0);
        rst = 1'b0;

        send(8'd7, 8'd7, 8'd1, 16'd50, 16'd50);
        send(8'd255, 8'd255, 8'd255, 16'd65280, 16'd65280);
        send(8'd0, 8'd200, 8'd0, 16'd0, 16'd0);
        drain(100);

        // Backpressure: hold out_ready low for 6 cycles of out_valid.
        rdy_mode = 1;
        send(8'd13, 8'd11, 8'd4, 16'd147, 16'd147);
        wc = 0;
        while (!out_valid && wc < 50) begin
            @(negedge clk);
            wc++;
        end
        check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
        repeat (6) @(posedge clk);
        rdy_mode = 2;
        drain(50);

        // Busy rejection: a second operand set during RUN must be ignored.
        send(8'd12, 8'd5, 8'd2, 16'd62, 16'd62);
        repeat (2) @(negedge clk);
        mcand = 8'd3; mplier = 8'd3; addend = 8'd0; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("in_ready_during_run", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        drain(50);

        // Reset in the middle of RUN aborts the operation.
        send(8'd5, 8'd9, 8'd1, 16'd46, 16'd46);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrun_product", {16'd0, product}, 32'd0);
        check("midrun_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrun_busy", {31'd0, busy}, 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'd9, 8'd6, 8'd3, 16'd57, 16'd57);
        drain(50);

`ifdef DIV_CHECK_EN
        send(8'd7, 8'd7, 8'd1, 16'd50, 16'd51);
        send(8'd7, 8'd7, 8'd8, 16'd57, 16'd57);
        send(8'd7, 8'd7, 8'd8, 16'd57, 16'd50);
        drain(100);
`endif

        // Random operands against the arithmetic reference, with random consumer stalls.
        rdy_mode = 0;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = W'($urandom);
            if (i < 3) a = 8'd255;
            if (i == 5) b = 8'd0;
            p = int'(a) * int'(b) + int'(c);
            chk = p[2*W-1:0];
            if ($urandom_range(0, 3) == 0) chk = chk ^ 16'd1;
            send(a, b, c, p[2*W-1:0], chk);
        end
        rdy_mode = 2;
        drain(500);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
